// File: rtl/risc_pc.sv
// Program counter register for the RV32I fetch stage.
// Holds the fetch address and either advances by STEP or loads a branch/jump target.
module risc_pc #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              STEP       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcEn,
  input  logic            pcSrc,
  input  logic [XLEN-1:0] addressInput,
  output logic [XLEN-1:0] pcOutput
);

  localparam logic [XLEN-1:0] STEP_V = XLEN'(STEP);

  logic [XLEN-1:0] pc;

  // Target is chosen by a mux select, so an X on addressInput never reaches pc
  // while the sequential path is in use.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_ADDR;
    end else if (pcEn) begin
      if (pcSrc) begin
        pc <= addressInput;
      end else begin
        pc <= pc + STEP_V;
      end
    end
  end

  assign pcOutput = pc;

endmodule

// File: tb/tb_risc_pc.sv
// Self-checking bench for risc_pc: directed test-plan sequences followed by
// randomized stimulus compared against an arithmetic reference model.
module tb_risc_pc;

  logic        clk;
  logic        rst;
  logic        pcEn;
  logic        pcSrc;
  logic [31:0] addressInput;
  logic [31:0] pcOutput;

  int checkCount = 0;
  int errorCount = 0;

  longint unsigned modelPc = 0;

  risc_pc #(
    .XLEN(32),
    .RESET_ADDR(32'h0000_0000),
    .STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pcEn(pcEn),
    .pcSrc(pcSrc),
    .addressInput(addressInput),
    .pcOutput(pcOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one edge worth of inputs, step the clock, and advance the model.
  // Outputs are then stable 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic en, input logic src, input logic [31:0] addr);
    rst          = r;
    pcEn         = en;
    pcSrc        = src;
    addressInput = addr;
    @(posedge clk);
    #1;
    if (r)
      modelPc = 0;
    else if (en && src)
      modelPc = longint'(addr);
    else if (en)
      modelPc = (modelPc + 4) % 64'h1_0000_0000;
  endtask

  initial begin
    logic        r, en, src;
    logic [31:0] addr;

    rst = 1'b1; pcEn = 1'b0; pcSrc = 1'b0; addressInput = '0;
    #2;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("reset", pcOutput, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("run1", pcOutput, 32'h0000_0004);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("run2", pcOutput, 32'h0000_0008);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("run3", pcOutput, 32'h0000_000C);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0020);
    checkOutput("branch", pcOutput, 32'h0000_0020);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("post_branch1", pcOutput, 32'h0000_0024);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("post_branch2", pcOutput, 32'h0000_0028);

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stall1", pcOutput, 32'h0000_0028);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    checkOutput("stall_redirect", pcOutput, 32'h0000_0028);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stall3", pcOutput, 32'h0000_0028);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("resume", pcOutput, 32'h0000_002C);

    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    checkOutput("reset_priority", pcOutput, 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("after_reset", pcOutput, 32'h0000_0004);

    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
    checkOutput("wrap_load", pcOutput, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap1", pcOutput, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap2", pcOutput, 32'h0000_0000);

    applyStimulus(1'b0, 1'b1, 1'b0, 32'hxxxx_xxxx);
    checkOutput("x_iso_value", pcOutput, 32'h0000_0004);
    checkOutput("x_iso_clean", {31'b0, $isunknown(pcOutput)}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hxxxx_xxxx);
    checkOutput("x_iso_stall", pcOutput, 32'h0000_0004);

    modelPc = 4;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 24) == 0);
      en  = ($urandom_range(0, 3) != 0);
      src = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       addr = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
        1:       addr = $urandom & 32'h0000_0FFC;
        default: addr = $urandom;
      endcase
      if (!(en && src) && $urandom_range(0, 1) == 1)
        addr = 32'hxxxx_xxxx;
      applyStimulus(r, en, src, addr);
      checkOutput("random_pc", pcOutput, modelPc[31:0]);
      if ($isunknown(pcOutput))
        checkOutput("random_x_free", {31'b0, $isunknown(pcOutput)}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
